instr_fetch: RTL and testbench



---
 rtl/proc_pkg.sv | 22 ++
 rtl/imem_sync.sv | 31 +++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared widths and types for the fetch stage: PC, instruction word and the
// {pc, instruction} packet handed to decode.
package proc_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 64;

    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] pc_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_pkt_t;

    // Sequential fetch address; wraps naturally at 2^ADDR_W.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/imem_sync.sv
// 64 x 32 instruction memory: one synchronous read-first read port and an
// independent write port used to load the program. The array is not reset.
module imem_sync
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Both updates are non-blocking, so a same-cycle write to the read
    // address leaves the old word in rd_data_q (read-first).
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, one outstanding synchronous memory read and a
// 2-entry skid buffer feeding decode over valid/ready, with redirect flush.
module instr_fetch
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              clkreset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    pc_t        pc_q,       pc_d;
    pc_t        rd_pc_q,    rd_pc_d;
    logic       inflight_q, inflight_d;
    logic [1:0] occ_q,      occ_d;
    fetch_pkt_t head_q,     head_d;
    fetch_pkt_t tail_q,     tail_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] level;
    instr_t     rd_data;
    fetch_pkt_t push_pkt;

    imem_sync u_imem (
        .clk       (clk),
        .rd_en_i   (issue),
        .rd_addr_i (pc_q),
        .rd_data_o (rd_data),
        .wr_en_i   (imem_we),
        .wr_addr_i (imem_waddr),
        .wr_data_i (imem_wdata)
    );

    assign pop      = (occ_q != 2'd0) && instr_ready;
    assign push     = inflight_q;
    assign push_pkt = '{pc: rd_pc_q, instr: rd_data};

    // Entries already held or on their way, minus the one leaving now; a new
    // read may only start if it is guaranteed a free slot when it returns.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = !redirect_valid && (level < 3'd2);

    always_comb begin
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = issue;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (issue) begin
            pc_d    = pc_next(pc_q);
            rd_pc_d = pc_q;
        end

        if (redirect_valid) begin
            pc_d  = redirect_pc;
            occ_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = push_pkt;
                        occ_d  = 2'd1;
                    end else begin
                        tail_d = push_pkt;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (occ_q == 2'd1) begin
                        head_d = push_pkt;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_pkt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clkreset) begin
        if (clkreset) begin
            pc_q       <= '0;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign instr_valid = (occ_q != 2'd0);
    assign instr       = head_q.instr;
    assign instr_pc    = head_q.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a sequence-level
// model: expected next PC, memory image and redirect/reset bubble length.
module tb_instr_fetch;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        clkreset = 1'b0;
    logic        imem_we = 1'b0;
    pc_t         imem_waddr = '0;
    instr_t      imem_wdata = '0;
    logic        redirect_valid = 1'b0;
    pc_t         redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    instr_t      instr;
    pc_t         instr_pc;

    int total = 0;
    int bad = 0;

    // Model state: next PC decode should accept, words it should see, and
    // how many more edges until output becomes valid after reset/redirect.
    pc_t    exp_pc = '0;
    instr_t mem_m [IMEM_DEPTH];
    int     wait_n = 2;

    instr_fetch dut (
        .clk            (clk),
        .clkreset       (clkreset),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check any handshake completing at this edge, advance the
    // model, then check valid and head stability after the edge.
    task automatic cycle();
        logic   pop_s;
        logic   redir_s;
        logic   hold_s;
        pc_t    rpc;
        pc_t    hpc;
        instr_t hins;
        pop_s   = instr_valid && instr_ready;
        redir_s = redirect_valid;
        hold_s  = instr_valid && !instr_ready && !redir_s;
        rpc     = redirect_pc;
        hpc     = instr_pc;
        hins    = instr;
        if (pop_s && !redir_s) begin
            chk("acc_pc", 64'(instr_pc), 64'(exp_pc));
            chk("acc_instr", 64'(instr), 64'(mem_m[exp_pc]));
            exp_pc = exp_pc + pc_t'(1);
        end
        @(posedge clk);
        #1;
        if (redir_s) begin
            exp_pc = rpc;
            wait_n = 2;
        end else if (wait_n > 0) begin
            wait_n--;
        end
        chk("valid", 64'(instr_valid), 64'(wait_n == 0));
        if (hold_s) begin
            chk("hold_pc", 64'(instr_pc), 64'(hpc));
            chk("hold_instr", 64'(instr), 64'(hins));
        end
    endtask

    task automatic release_reset();
        clkreset    = 1'b0;
        exp_pc      = '0;
        wait_n      = 2;
    endtask

    initial begin
        int n;
        #1 clkreset = 1'b1;

        // Load the program while reset holds the fetch logic idle.
        for (int a = 0; a < IMEM_DEPTH; a++) begin
            imem_we    = 1'b1;
            imem_waddr = pc_t'(a);
            imem_wdata = 32'hA000_0000 + 32'(a);
            mem_m[a]   = 32'hA000_0000 + 32'(a);
            @(posedge clk);
            #1;
        end
        imem_we = 1'b0;

        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_pc", 64'(instr_pc), 64'(0));
        chk("rst_pcq", 64'(dut.pc_q), 64'(0));

        // Streaming with a 5-cycle stall while pc 4 is at the head.
        instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 6; i++) cycle();
        chk("pre_stall_pc", 64'(instr_pc), 64'(4));
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_head", 64'(instr_pc), 64'(4));
        chk("stall_pcq", 64'(dut.pc_q), 64'(6));
        instr_ready = 1'b1;
        for (int i = 0; i < 70; i++) cycle();

        // Redirect to 40 with pcs 10 and 11 buffered.
        n = 0;
        while (!(instr_valid && instr_pc == pc_t'(10)) && n < 100) begin
            cycle();
            n++;
        end
        chk("to_pc10", 64'(n < 100), 64'(1));
        instr_ready = 1'b0;
        cycle();
        cycle();
        chk("full_head", 64'(instr_pc), 64'(10));
        redirect_valid = 1'b1;
        redirect_pc    = pc_t'(40);
        cycle();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("redir_pc", 64'(exp_pc), 64'(41));

        // Asynchronous reset with a full buffer.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("prerst_valid", 64'(instr_valid), 64'(1));
        clkreset = 1'b1;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'(0));
        chk("arst_instr", 64'(instr), 64'(0));
        chk("arst_pc", 64'(instr_pc), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        release_reset();

        // Write address 7 on the edge that issues pc 7: old word comes out.
        for (int i = 0; i < 7; i++) cycle();
        imem_we    = 1'b1;
        imem_waddr = pc_t'(7);
        imem_wdata = 32'hDEAD_BEEF;
        cycle();
        imem_we = 1'b0;
        n = 0;
        while (exp_pc != pc_t'(8) && n < 20) begin
            cycle();
            n++;
        end
        chk("to_old7", 64'(n < 20), 64'(1));
        mem_m[7] = 32'hDEAD_BEEF;
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = pc_t'(7);
        cycle();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        n = 0;
        while (exp_pc != pc_t'(8) && n < 20) begin
            cycle();
            n++;
        end
        chk("to_new7", 64'(n < 20), 64'(1));

        // Random ready and occasional redirects.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                instr_ready    = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = pc_t'($urandom);
                cycle();
                redirect_valid = 1'b0;
            end else begin
                instr_ready = 1'($urandom);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
